reg_file_arbiter: RTL and testbench
===================================

Name: reg_file_arbiter

Overview:
- Write-port controller for a single-write-port register file (synchronous write, asynchronous read).
- Shares the one write port between two requesters (A, B) using valid/ready handshakes and round-robin arbitration.
- Runs a clear sweep that writes zero to every address, both after reset and on demand.
- Sits directly in front of the register file's we/address_w/data_w inputs; the read port bypasses this block.

Parameters:
- ADDR_WIDTH, 7, register file address width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 8, register file data width.
- CLEAR_ON_RESET, 1, 1 = enter CLEAR on reset release; 0 = go straight to SERVE.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- clear_req  input  1  level; sampled in SERVE, starts a zero-fill sweep.
- a_valid  input  1  requester A has a write pending.
- a_addr  input  ADDR_WIDTH  requester A write address.
- a_data  input  DATA_WIDTH  requester A write data.
- a_ready  output  1  A's write accepted at this edge if a_valid=1.
- b_valid  input  1  requester B has a write pending.
- b_addr  input  ADDR_WIDTH  requester B write address.
- b_data  input  DATA_WIDTH  requester B write data.
- b_ready  output  1  B's write accepted at this edge if b_valid=1.
- we  output  1  registered; to register file we.
- address_w  output  ADDR_WIDTH  registered; to register file address_w.
- data_w  output  DATA_WIDTH  registered; to register file data_w.
- busy  output  1  1 while in CLEAR.
- clear_done  output  1  registered one-cycle pulse after the last sweep write is issued.

Behaviour:
- Reset (reset_n=0, async): we=0, address_w=0, data_w=0, clear_done=0, sweep counter=0, prio=A. State = CLEAR if CLEAR_ON_RESET=1, else SERVE. busy follows state immediately.
- States: CLEAR, SERVE. No other states.
- CLEAR:
  - Each cycle: we<=1, address_w<=cnt, data_w<=0, cnt<=cnt+1.
  - At cnt = 2**ADDR_WIDTH-1: issue the final write, set cnt<=0, clear_done<=1, next state SERVE.
  - Sweep is exactly 2**ADDR_WIDTH cycles (128 by default).
  - a_ready=b_ready=0 throughout; clear_req is ignored.
- SERVE handshake (combinational):
  - a_ready = !clear_req && (!b_valid || prio==A).
  - b_ready = !clear_req && (!a_valid || prio==B).
  - A transfer occurs at a rising edge where valid && ready.
  - At most one transfer per cycle.
  - A requester must hold valid/addr/data stable until its transfer.
- SERVE write pipeline:
  - On a transfer: we<=1, address_w<=winner addr, data_w<=winner data.
  - With no transfer: we<=0; address_w and data_w hold their values.
  - Latency: transfer at edge t → we high during cycle t..t+1 → register file written at edge t+1.
- Round-robin:
  - After every transfer, prio<=other requester.
  - A lone requester is granted every cycle (back-to-back, no bubbles).
  - With both valid continuously, grants strictly alternate.
- clear_req in SERVE:
  - Readies are forced 0 that cycle.
  - Next state is CLEAR with cnt=0.
  - A write already in the output register (we=1) still completes at the next edge.
- clear_done is high exactly one cycle: the first SERVE cycle after a sweep. It is 0 otherwise.
- Reset asserted mid-sweep or mid-write: everything returns to reset values immediately. The sweep restarts from address 0 after release when CLEAR_ON_RESET=1.
- Counter width is ADDR_WIDTH; wrap-around is only via the explicit terminal-count compare.
- No read-after-write bypass. A read of an address in the same cycle as its write returns old data, per register file behaviour.

Test Plan:
- Reset release, CLEAR_ON_RESET=1 → busy=1 for 128 cycles; we=1 with address_w 0..127 and data_w=0; then clear_done pulses once; all 128 entries read 0.
- SERVE, A only: a_valid=1, a_addr=0x05, a_data=0xA5 for one cycle → a_ready=1; next cycle we=1, address_w=0x05, data_w=0xA5; register file address 5 reads 0xA5 after the following edge.
- Contention: a_valid=b_valid=1 for 4 cycles with prio=A → grant order A,B,A,B; the register file holds both requesters' data at their addresses.
- B only, 3 consecutive writes (addr 1,2,3; data 0x11,0x22,0x33) → b_ready=1 every cycle, we=1 for 3 consecutive cycles, no bubbles.
- clear_req pulsed while a_valid=1 → a_ready=0 that cycle; a 128-cycle sweep follows; A's write is accepted only after clear_done, and A's data persists afterwards.
- reset_n asserted at sweep address 60 → we=0 and busy=1 immediately; after release the sweep restarts at address 0.

Source files
------------

// File: rtl/reg_file_arbiter.sv
// Write-port controller for a single-write-port register file: round-robin
// sharing between requesters A and B, plus a zero-fill clear sweep.
module reg_file_arbiter #(
    parameter int ADDR_WIDTH     = 7,
    parameter int DATA_WIDTH     = 8,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear_req,
    input  logic                  a_valid,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  b_ready,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] address_w,
    output logic [DATA_WIDTH-1:0] data_w,
    output logic                  busy,
    output logic                  clear_done
);

    typedef enum logic {
        CLEAR,
        SERVE
    } state_t;

    typedef enum logic {
        PRIO_A,
        PRIO_B
    } prio_t;

    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = {ADDR_WIDTH{1'b1}};

    state_t                  state;
    prio_t                   prio;
    logic [ADDR_WIDTH-1:0]   cnt;
    logic                    a_fire;
    logic                    b_fire;

    // With both valid, exactly one ready is high, so at most one transfer per cycle.
    always_comb begin
        busy    = (state == CLEAR);
        a_ready = (state == SERVE) && !clear_req && (!b_valid || prio == PRIO_A);
        b_ready = (state == SERVE) && !clear_req && (!a_valid || prio == PRIO_B);
        a_fire  = a_valid && a_ready;
        b_fire  = b_valid && b_ready;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= CLEAR_ON_RESET ? CLEAR : SERVE;
            prio       <= PRIO_A;
            cnt        <= '0;
            we         <= 1'b0;
            address_w  <= '0;
            data_w     <= '0;
            clear_done <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            case (state)
                CLEAR: begin
                    we        <= 1'b1;
                    address_w <= cnt;
                    data_w    <= '0;
                    if (cnt == CNT_LAST) begin
                        cnt        <= '0;
                        clear_done <= 1'b1;
                        state      <= SERVE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SERVE: begin
                    // A write already held in the output register still lands at this edge.
                    if (clear_req) begin
                        we    <= 1'b0;
                        cnt   <= '0;
                        state <= CLEAR;
                    end else if (a_fire) begin
                        we        <= 1'b1;
                        address_w <= a_addr;
                        data_w    <= a_data;
                        prio      <= PRIO_B;
                    end else if (b_fire) begin
                        we        <= 1'b1;
                        address_w <= b_addr;
                        data_w    <= b_data;
                        prio      <= PRIO_A;
                    end else begin
                        we <= 1'b0;
                    end
                end
                default: begin
                    state <= SERVE;
                    we    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Directed bench for reg_file_arbiter with a behavioural register file
// behind the write port.
module tb_reg_file_arbiter;

    localparam int AW    = 7;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          clear_req;
    logic          a_valid;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_data;
    logic          a_ready;
    logic          b_valid;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_data;
    logic          b_ready;
    logic          we;
    logic [AW-1:0] address_w;
    logic [DW-1:0] data_w;
    logic          busy;
    logic          clear_done;

    logic [DW-1:0] rf [DEPTH];
    logic          rf_init;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_file_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear_req  (clear_req),
        .a_valid    (a_valid),
        .a_addr     (a_addr),
        .a_data     (a_data),
        .a_ready    (a_ready),
        .b_valid    (b_valid),
        .b_addr     (b_addr),
        .b_data     (b_data),
        .b_ready    (b_ready),
        .we         (we),
        .address_w  (address_w),
        .data_w     (data_w),
        .busy       (busy),
        .clear_done (clear_done)
    );

    // Register file model, pre-filled with 0xFF so the clear sweep is observable.
    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < DEPTH; i++) rf[i] <= 8'hFF;
        end else if (we) begin
            rf[address_w] <= data_w;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                                 input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                                 input logic cr);
        a_valid   = av;
        a_addr    = aa;
        a_data    = ad;
        b_valid   = bv;
        b_addr    = ba;
        b_data    = bd;
        clear_req = cr;
        #1;
    endtask

    // Expects the DUT to already be in CLEAR with the counter at 0.
    task automatic runSweep(input string tag);
        for (int k = 0; k < DEPTH; k++) begin
            checkOutput({tag, "_busy"}, busy, 1);
            checkOutput({tag, "_a_ready"}, a_ready, 0);
            checkOutput({tag, "_b_ready"}, b_ready, 0);
            stepClock();
            checkOutput({tag, "_we"}, we, 1);
            checkOutput({tag, "_addr"}, address_w, k);
            checkOutput({tag, "_data"}, data_w, 0);
            checkOutput({tag, "_done"}, clear_done, (k == DEPTH - 1) ? 1 : 0);
        end
        checkOutput({tag, "_busy_end"}, busy, 0);
    endtask

    logic [AW-1:0] c_a_addr [5] = '{7'h40, 7'h41, 7'h41, 7'h42, 7'h42};
    logic [DW-1:0] c_a_data [5] = '{8'hA0, 8'hA1, 8'hA1, 8'hA2, 8'hA2};
    logic          c_b_vld  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [AW-1:0] c_b_addr [5] = '{7'h50, 7'h50, 7'h51, 7'h51, 7'h00};
    logic [DW-1:0] c_b_data [5] = '{8'hB0, 8'hB0, 8'hB1, 8'hB1, 8'h00};
    logic          c_grant_a[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        int nonzero;
        rf_init = 1'b1;
        reset_n = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        checkOutput("rst_we", we, 0);
        checkOutput("rst_addr", address_w, 0);
        checkOutput("rst_data", data_w, 0);
        checkOutput("rst_done", clear_done, 0);
        checkOutput("rst_busy", busy, 1);
        checkOutput("rst_a_ready", a_ready, 0);
        stepClock();
        stepClock();
        checkOutput("rst_we_held", we, 0);
        rf_init = 1'b0;
        reset_n = 1'b1;

        runSweep("init");
        stepClock();
        checkOutput("init_done_pulse", clear_done, 0);
        checkOutput("init_we_off", we, 0);
        nonzero = 0;
        for (int i = 0; i < DEPTH; i++) if (rf[i] != 0) nonzero++;
        checkOutput("init_all_zero", nonzero, 0);

        // Lone requester A
        applyStimulus(1, 7'h05, 8'hA5, 0, 0, 0, 0);
        checkOutput("a_only_ready", a_ready, 1);
        stepClock();
        checkOutput("a_only_we", we, 1);
        checkOutput("a_only_addr", address_w, 7'h05);
        checkOutput("a_only_data", data_w, 8'hA5);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        stepClock();
        checkOutput("a_only_we_off", we, 0);
        checkOutput("a_only_rf", rf[5], 8'hA5);

        // Lone requester B, back-to-back
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(0, 0, 0, 1, AW'(i), DW'(i * 8'h11), 0);
            checkOutput("b_only_ready", b_ready, 1);
            stepClock();
            checkOutput("b_only_we", we, 1);
            checkOutput("b_only_addr", address_w, i);
            checkOutput("b_only_data", data_w, i * 8'h11);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        stepClock();
        checkOutput("b_only_we_off", we, 0);
        checkOutput("b_only_rf1", rf[1], 8'h11);
        checkOutput("b_only_rf2", rf[2], 8'h22);
        checkOutput("b_only_rf3", rf[3], 8'h33);

        // Contention starting with prio=A, then A alone
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1, c_a_addr[c], c_a_data[c], c_b_vld[c], c_b_addr[c], c_b_data[c], 0);
            checkOutput("cont_a_ready", a_ready, c_grant_a[c]);
            checkOutput("cont_b_ready", b_ready, !c_grant_a[c]);
            stepClock();
            checkOutput("cont_we", we, 1);
            checkOutput("cont_addr", address_w, c_grant_a[c] ? c_a_addr[c] : c_b_addr[c]);
            checkOutput("cont_data", data_w, c_grant_a[c] ? c_a_data[c] : c_b_data[c]);
        end

        // clear_req while A waits and a write is still in the output register
        applyStimulus(1, 7'h33, 8'h5C, 0, 0, 0, 1);
        checkOutput("creq_a_ready", a_ready, 0);
        checkOutput("creq_b_ready", b_ready, 0);
        checkOutput("creq_we_pending", we, 1);
        stepClock();
        checkOutput("creq_we_off", we, 0);
        checkOutput("cont_rf40", rf[7'h40], 8'hA0);
        checkOutput("cont_rf41", rf[7'h41], 8'hA1);
        checkOutput("cont_rf42", rf[7'h42], 8'hA2);
        checkOutput("cont_rf50", rf[7'h50], 8'hB0);
        checkOutput("cont_rf51", rf[7'h51], 8'hB1);
        applyStimulus(1, 7'h33, 8'h5C, 0, 0, 0, 0);
        runSweep("creq");
        checkOutput("creq_a_ready_after", a_ready, 1);
        stepClock();
        checkOutput("creq_a_we", we, 1);
        checkOutput("creq_a_addr", address_w, 7'h33);
        checkOutput("creq_a_data", data_w, 8'h5C);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        stepClock();
        checkOutput("creq_rf33", rf[7'h33], 8'h5C);
        checkOutput("creq_rf40_cleared", rf[7'h40], 8'h00);
        stepClock();
        stepClock();
        stepClock();
        checkOutput("creq_rf33_persist", rf[7'h33], 8'h5C);

        // Reset in the middle of a sweep
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        stepClock();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k <= 60; k++) stepClock();
        checkOutput("mid_addr60", address_w, 60);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_we", we, 0);
        checkOutput("mid_rst_busy", busy, 1);
        checkOutput("mid_rst_addr", address_w, 0);
        checkOutput("mid_rst_done", clear_done, 0);
        stepClock();
        stepClock();
        reset_n = 1'b1;
        runSweep("rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
